ifetch: RTL
===========

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set fetch-buffer entries (power of two, 2..8); credits = DEPTH.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 xreset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 next_pc  input  32  SHALL be the fetch address supplied by the PC block.
REQ-005 flush  input  1  SHALL be the redirect strobe, asserted with the PC block's jreq.
REQ-006 halt  output  1  SHALL be the PC-hold request returned to the PC block; 1 = hold pc/next_pc.
REQ-007 imem_req  output  1  SHALL be the instruction-memory request valid.
REQ-008 imem_addr  output  32  SHALL be the request address.
REQ-009 imem_gnt  input  1  SHALL accept the request in the cycle it is high with imem_req.
REQ-010 imem_rvalid  input  1  SHALL mark a read response; responses return in request order, >=1 cycle after grant.
REQ-011 imem_rdata  input  32  SHALL be the response data, valid with imem_rvalid.
REQ-012 inst_valid  output  1  SHALL flag a buffered instruction presented to decode.
REQ-013 inst  output  32  SHALL be the head instruction word.
REQ-014 inst_pc  output  32  SHALL be the address the head instruction was fetched from.
REQ-015 inst_ready  input  1  SHALL pop the head when high with inst_valid.

Function
REQ-016 Buffer: circular DEPTH-entry array of {addr, data, filled}; alloc at tail on grant, fill at oldest unfilled entry on rvalid, pop at head.
REQ-017 count = allocated entries; discard = dropped in-flight responses; both log2(DEPTH)+1 bits.
REQ-018 imem_req SHALL be 1 iff xreset_n=1, flush=0, and count+discard < DEPTH.
REQ-019 imem_addr SHALL equal next_pc combinationally.
REQ-020 halt SHALL be 0 iff flush=1 or (imem_req and imem_gnt); 1 otherwise, including while xreset_n=0.
REQ-021 Grant: entry {addr=next_pc, filled=0} allocated at next edge; PC advances same edge since halt=0.
REQ-022 rvalid with discard>0 SHALL drop the data and decrement discard; no entry written.
REQ-023 rvalid with discard=0 SHALL write imem_rdata into the oldest unfilled entry and set filled.
REQ-024 inst_valid SHALL be 1 iff count>0, head entry filled, and flush=0; inst/inst_pc from head entry.
REQ-025 Latency: response at edge t -> inst_valid high in cycle t+1 (registered), if it is the head.
REQ-026 Flush SHALL, at the edge: clear all entries (count=0), set discard = unfilled outstanding entries + discard - (1 if rvalid that cycle else 0); no pop, no alloc.
REQ-027 Simultaneous grant, fill, and pop in one cycle SHALL all take effect; count changes by alloc-pop.
REQ-028 Full (count+discard = DEPTH): imem_req=0, halt=1; requests resume the cycle after a pop or drop frees a credit.
REQ-029 Head/tail pointers SHALL wrap modulo DEPTH; no pointer or counter overflows under legal traffic.
REQ-030 rvalid with no unfilled entry and discard=0 is a protocol violation; SHALL be ignored without state change.

Reset
REQ-031 xreset_n=0 SHALL immediately clear count, discard, pointers, and filled bits; outputs imem_req=0, halt=1, inst_valid=0.
REQ-032 Reset SHALL abandon any in-flight memory transaction; responses arriving after deassertion fall under REQ-030.
REQ-033 First request SHALL issue the first cycle with xreset_n=1, using next_pc (0 from the PC block).

Verification
REQ-034 Reset release, gnt=1, rvalid one cycle later, ready=1 -> imem_addr 0,4,8...; inst_pc 0,4,8 back-to-back, halt=0 throughout.
REQ-035 gnt=0 for 3 cycles at next_pc=0x10 -> halt=1, imem_addr stays 0x10; on gnt=1 halt=0 and PC steps to 0x14.
REQ-036 ready=0, DEPTH=4, 4 grants and 4 responses -> count=4, imem_req=0, halt=1; one pop -> imem_req=1 next cycle.
REQ-037 Two outstanding at 0x20/0x24, flush with jval=0x100 -> halt=0 that cycle, both later responses dropped, first inst_pc after flush = 0x100.
REQ-038 Flush coincident with rvalid, one other outstanding -> that response dropped, discard=1, next response dropped, none reach decode.
REQ-039 xreset_n low mid-stream with 3 entries -> inst_valid=0, imem_req=0 asynchronously; restart fetch from 0 after release.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch front end: issues imem requests against a credit budget and
// buffers in-order responses in a DEPTH-entry ring for decode, with flush/discard.
package ifetch_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        filled;
  } fb_entry_t;
endpackage

module ifetch_entry
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        alloc,
  input  logic [31:0] alloc_addr,
  input  logic        fill,
  input  logic [31:0] fill_data,
  input  logic        pop,
  output fb_entry_t   ent
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent <= '0;
    end else if (clear) begin
      ent.filled <= 1'b0;
    end else begin
      if (alloc) begin
        ent.addr   <= alloc_addr;
        ent.filled <= 1'b0;
      end
      if (fill) begin
        ent.data   <= fill_data;
        ent.filled <= 1'b1;
      end
      if (pop) ent.filled <= 1'b0;
    end
  end
endmodule

module ifetch
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        xreset_n,
  input  logic [31:0] next_pc,
  input  logic        flush,
  output logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] head, tail, fptr;
  logic [CW-1:0] count, pend, discard, used;
  fb_entry_t [DEPTH-1:0] ents;
  fb_entry_t head_ent;
  logic alloc, pop, drop, fill;

  assign used       = count + discard;
  assign imem_req   = xreset_n & ~flush & (used < DEPTH_C);
  assign imem_addr  = next_pc;
  assign alloc      = imem_req & imem_gnt;
  assign halt       = ~xreset_n | ~(flush | alloc);

  assign head_ent   = ents[head];
  assign inst_valid = (count != '0) & head_ent.filled & ~flush;
  assign inst       = head_ent.data;
  assign inst_pc    = head_ent.addr;

  assign pop  = inst_valid & inst_ready;
  assign drop = imem_rvalid & (discard != '0);
  // Entries fill strictly in order, so head..fptr are filled and fptr..tail pending.
  assign fill = imem_rvalid & (discard == '0) & (pend != '0);

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      ifetch_entry u_ent (
        .clk        (clk),
        .rst_n      (xreset_n),
        .clear      (flush),
        .alloc      (alloc && (tail == AW'(i))),
        .alloc_addr (next_pc),
        .fill       (fill && (fptr == AW'(i))),
        .fill_data  (imem_rdata),
        .pop        (pop && (head == AW'(i))),
        .ent        (ents[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge xreset_n) begin
    if (!xreset_n) begin
      head    <= '0;
      tail    <= '0;
      fptr    <= '0;
      count   <= '0;
      pend    <= '0;
      discard <= '0;
    end else if (flush) begin
      // Every pending request becomes a response to throw away; a response
      // arriving this very cycle is already accounted for.
      head    <= tail;
      fptr    <= tail;
      count   <= '0;
      pend    <= '0;
      discard <= discard + pend - CW'(imem_rvalid && ((discard + pend) != '0));
    end else begin
      tail    <= tail + AW'(alloc);
      fptr    <= fptr + AW'(fill);
      head    <= head + AW'(pop);
      count   <= count + CW'(alloc) - CW'(pop);
      pend    <= pend + CW'(alloc) - CW'(fill);
      discard <= discard - CW'(drop);
    end
  end
endmodule
